pmp_arbiter: RTL and testbench

Sequencer and arbiter sharing the single `pmp` checker between the instruction-fetch and load/store units, plus the PMP CSR write path. Each requester gets a registered fault/allow response. Requests are latched, presented to `pmp`, sampled, and returned with fixed latency. CSR writes are serialised against checks so that no check ever sees a half-updated configuration.

---
 rtl/pmp_pkg.sv | 22 ++
 rtl/pmp_rr_arb.sv | 30 +++
 rtl/pmp_arbiter.sv | 140 ++++++++++++++
 tb/tb_pmp_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pmp_pkg.sv
// pmp_pkg: shared state, operation and size encodings for the PMP arbiter.
package pmp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_RESP   = 3'd2,
    ST_CSR_WR = 3'd3,
    ST_SETTLE = 3'd4
  } state_e;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_EXEC  = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int PERM_ALLOW_BIT = 0;

endpackage

// File: rtl/pmp_rr_arb.sv
// pmp_rr_arb: 2-way round-robin arbiter (bit 0 = fetch, bit 1 = LSU).
// Only built when PMP_ARB_RR_EN is defined.
`ifdef PMP_ARB_RR_EN
module pmp_rr_arb (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_ls;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    gnt = req;
    if (req[0] && req[1]) begin
      gnt = last_ls ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_ls <= 1'b1;
    end else if (|gnt) begin
      last_ls <= gnt[1];
    end
  end

endmodule
`endif

// File: rtl/pmp_arbiter.sv
// pmp_arbiter: shares one PMP checker between fetch, LSU and the PMP CSR write path.
// Define PMP_ARB_RR_EN for round-robin fetch/LSU arbitration; default is LSU-over-fetch priority.
module pmp_arbiter
  import pmp_pkg::*;
#(
  parameter int AW     = 32,
  parameter int SETTLE = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req_valid,
  input  logic          ls_req_valid,
  output logic          if_req_ready,
  output logic          ls_req_ready,
  input  logic [AW-1:0] if_addr,
  input  logic [AW-1:0] ls_addr,
  input  logic [1:0]    if_size,
  input  logic [1:0]    ls_size,
  input  logic [1:0]    ls_oper,
  input  logic [1:0]    priv_mode,
  output logic          if_resp_valid,
  output logic          ls_resp_valid,
  output logic          if_resp_fault,
  output logic          ls_resp_fault,
  input  logic          csr_wr_valid,
  output logic          csr_wr_ready,
  input  logic [AW-1:0] csr_addr,
  input  logic [31:0]   csr_wdata,
  output logic [31:0]   csr_rdata,
  output logic [AW-1:0] pmp_addr,
  output logic [1:0]    pmp_size,
  output logic [1:0]    pmp_oper,
  output logic [1:0]    pmp_priv_mode,
  output logic          pmp_wr_en,
  output logic [AW-1:0] pmp_rw_addr,
  output logic [31:0]   pmp_wdata,
  input  logic [1:0]    pmp_permission,
  input  logic [31:0]   pmp_rdata
);

  localparam logic [1:0] SETTLE_INIT = (SETTLE > 0) ? 2'(SETTLE - 1) : 2'd0;

  state_e        state, state_nxt;
  logic [AW-1:0] addr_q, wr_addr_q;
  logic [31:0]   wr_data_q;
  logic [1:0]    size_q, oper_q, priv_q, settle_cnt;
  logic          owner_ls_q, fault_q;
  logic          idle, grant_en, resp_cyc;
  logic [1:0]    arb_req, gnt;
  logic          unused_perm;

  // Pending CSR writes block check grants so the checker never sees a half-written config.
  assign idle     = reset && (state == ST_IDLE);
  assign grant_en = idle && !csr_wr_valid;
  assign arb_req  = {ls_req_valid, if_req_valid} & {2{grant_en}};

`ifdef PMP_ARB_RR_EN
  pmp_rr_arb u_rr_arb (
    .clock (clock),
    .reset (reset),
    .req   (arb_req),
    .gnt   (gnt)
  );
`else
  assign gnt = {arb_req[1], arb_req[0] & ~arb_req[1]};
`endif

  assign if_req_ready = gnt[0];
  assign ls_req_ready = gnt[1];
  assign csr_wr_ready = idle && csr_wr_valid;

  assign resp_cyc      = (state == ST_RESP);
  assign if_resp_valid = resp_cyc && !owner_ls_q;
  assign ls_resp_valid = resp_cyc && owner_ls_q;
  assign if_resp_fault = if_resp_valid && fault_q;
  assign ls_resp_fault = ls_resp_valid && fault_q;

  assign pmp_addr      = addr_q;
  assign pmp_size      = size_q;
  assign pmp_oper      = oper_q;
  assign pmp_priv_mode = priv_q;
  assign pmp_wr_en     = (state == ST_CSR_WR);
  assign pmp_rw_addr   = pmp_wr_en ? wr_addr_q : csr_addr;
  assign pmp_wdata     = wr_data_q;
  assign csr_rdata     = pmp_rdata;
  assign unused_perm   = pmp_permission[1];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (csr_wr_ready)  state_nxt = ST_CSR_WR;
        else if (|gnt)     state_nxt = ST_CHECK;
      end
      ST_CHECK:  state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      ST_CSR_WR: state_nxt = (SETTLE > 0) ? ST_SETTLE : ST_IDLE;
      ST_SETTLE: if (settle_cnt == 2'd0) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Request fields are captured at grant and held until the next grant.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      size_q     <= SZ_BYTE;
      oper_q     <= OP_READ;
      priv_q     <= 2'd0;
      owner_ls_q <= 1'b0;
      fault_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      settle_cnt <= 2'd0;
    end else begin
      state <= state_nxt;
      if (csr_wr_ready) begin
        wr_addr_q <= csr_addr;
        wr_data_q <= csr_wdata;
      end
      if (|gnt) begin
        owner_ls_q <= gnt[1];
        addr_q     <= gnt[1] ? ls_addr : if_addr;
        size_q     <= gnt[1] ? ls_size : if_size;
        oper_q     <= gnt[1] ? ls_oper : OP_EXEC;
        priv_q     <= priv_mode;
      end
      if (state == ST_CHECK) begin
        fault_q <= ~pmp_permission[PERM_ALLOW_BIT];
      end
      if (state == ST_CSR_WR) begin
        settle_cnt <= SETTLE_INIT;
      end else if (state == ST_SETTLE && settle_cnt != 2'd0) begin
        settle_cnt <= settle_cnt - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_pmp_arbiter.sv
// tb_pmp_arbiter: table-driven check of the PMP arbiter plus hand sequences for
// CSR serialisation, fetch/LSU arbitration order and reset during a check.
module tb_pmp_arbiter;
  import pmp_pkg::*;

  localparam int AW = 32;
  localparam int NV = 20;
`ifdef PMP_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          if_req_valid, ls_req_valid, if_req_ready, ls_req_ready;
  logic [AW-1:0] if_addr, ls_addr;
  logic [1:0]    if_size, ls_size, ls_oper, priv_mode;
  logic          if_resp_valid, ls_resp_valid, if_resp_fault, ls_resp_fault;
  logic          csr_wr_valid, csr_wr_ready;
  logic [AW-1:0] csr_addr;
  logic [31:0]   csr_wdata, csr_rdata;
  logic [AW-1:0] pmp_addr, pmp_rw_addr;
  logic [1:0]    pmp_size, pmp_oper, pmp_priv_mode;
  logic          pmp_wr_en;
  logic [31:0]   pmp_wdata;
  logic [1:0]    pmp_permission;
  logic [31:0]   pmp_rdata;

  int n_vec;
  int n_miss;
  int got;
  logic granted;

  always #5 clock = ~clock;

  pmp_arbiter #(.AW(AW), .SETTLE(1)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .ls_req_valid(ls_req_valid),
    .if_req_ready(if_req_ready), .ls_req_ready(ls_req_ready),
    .if_addr(if_addr), .ls_addr(ls_addr), .if_size(if_size), .ls_size(ls_size),
    .ls_oper(ls_oper), .priv_mode(priv_mode),
    .if_resp_valid(if_resp_valid), .ls_resp_valid(ls_resp_valid),
    .if_resp_fault(if_resp_fault), .ls_resp_fault(ls_resp_fault),
    .csr_wr_valid(csr_wr_valid), .csr_wr_ready(csr_wr_ready),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .pmp_addr(pmp_addr), .pmp_size(pmp_size), .pmp_oper(pmp_oper),
    .pmp_priv_mode(pmp_priv_mode), .pmp_wr_en(pmp_wr_en),
    .pmp_rw_addr(pmp_rw_addr), .pmp_wdata(pmp_wdata),
    .pmp_permission(pmp_permission), .pmp_rdata(pmp_rdata)
  );

  typedef struct packed {
    logic        rst;
    logic        ifv;
    logic        lsv;
    logic        csrv;
    logic [1:0]  oper;
    logic [1:0]  perm;
    logic [7:0]  exp_ctl;
    logic        chk;
    logic [31:0] exp_addr;
    logic [1:0]  exp_size;
    logic [1:0]  exp_oper;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic rst, input logic ifv, input logic lsv,
                              input logic csrv, input logic [1:0] oper,
                              input logic [1:0] perm, input logic [7:0] exp_ctl,
                              input logic chk, input logic [31:0] exp_addr,
                              input logic [1:0] exp_size, input logic [1:0] exp_oper);
    vec_t v;
    v.rst = rst; v.ifv = ifv; v.lsv = lsv; v.csrv = csrv;
    v.oper = oper; v.perm = perm; v.exp_ctl = exp_ctl; v.chk = chk;
    v.exp_addr = exp_addr; v.exp_size = exp_size; v.exp_oper = exp_oper;
    return v;
  endfunction

  // {if_rdy, ls_rdy, csr_rdy, if_rv, if_fault, ls_rv, ls_fault, wr_en}
  function automatic logic [7:0] outBits();
    return {if_req_ready, ls_req_ready, csr_wr_ready, if_resp_valid,
            if_resp_fault, ls_resp_valid, ls_resp_fault, pmp_wr_en};
  endfunction

  function automatic logic [1:0] expGrant(input int k);
    return RR_EN ? ((k % 2 == 0) ? 2'b10 : 2'b01) : 2'b01;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset          = v.rst;
    if_req_valid   = v.ifv;
    ls_req_valid   = v.lsv;
    csr_wr_valid   = v.csrv;
    ls_oper        = v.oper;
    pmp_permission = v.perm;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] got_v,
                             input logic [63:0] want_v);
    n_vec++;
    if (got_v !== want_v) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, got_v, want_v);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic holdReset(input int n);
    if_req_valid = 1'b0; ls_req_valid = 1'b0; csr_wr_valid = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < n; i++) nextCycle();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_vec = 0; n_miss = 0; got = 0; granted = 1'b0;
    reset = 1'b0; if_req_valid = 1'b1; ls_req_valid = 1'b1; csr_wr_valid = 1'b1;
    if_addr = 32'h0000_1000; ls_addr = 32'h8000_0000;
    if_size = SZ_WORD; ls_size = SZ_HALF; ls_oper = OP_WRITE; priv_mode = 2'd3;
    csr_addr = 32'h3A0; csr_wdata = 32'h1F; pmp_permission = 2'b00;
    pmp_rdata = 32'h1234_5678;

    vecs[0]  = mk(0, 1, 1, 1, OP_WRITE, 2'b00, 8'h00, 1, 32'h0, SZ_BYTE, OP_READ);
    vecs[1]  = mk(0, 1, 1, 1, OP_WRITE, 2'b00, 8'h00, 0, 32'h0, SZ_BYTE, OP_READ);
    vecs[2]  = mk(0, 1, 1, 1, OP_WRITE, 2'b00, 8'h00, 1, 32'h0, SZ_BYTE, OP_READ);
    vecs[3]  = mk(1, 1, 1, 1, OP_WRITE, 2'b00, 8'b0010_0000, 0, 32'h0, SZ_BYTE, OP_READ);
    vecs[4]  = mk(1, 1, 1, 0, OP_WRITE, 2'b00, 8'b0000_0001, 0, 32'h0, SZ_BYTE, OP_READ);
    vecs[5]  = mk(1, 1, 1, 0, OP_WRITE, 2'b00, 8'h00, 0, 32'h0, SZ_BYTE, OP_READ);
    vecs[6]  = mk(1, 1, 1, 0, OP_WRITE, 2'b00, RR_EN ? 8'b1000_0000 : 8'b0100_0000,
                  0, 32'h0, SZ_BYTE, OP_READ);
    vecs[7]  = mk(1, 0, 0, 0, OP_WRITE, 2'b00, 8'h00, 1,
                  RR_EN ? 32'h0000_1000 : 32'h8000_0000, RR_EN ? SZ_WORD : SZ_HALF,
                  RR_EN ? OP_EXEC : OP_WRITE);
    vecs[8]  = mk(1, 0, 0, 0, OP_WRITE, 2'b00, RR_EN ? 8'b0001_1000 : 8'b0000_0110,
                  0, 32'h0, SZ_BYTE, OP_READ);
    vecs[9]  = mk(1, 0, 0, 0, OP_WRITE, 2'b00, 8'h00, 0, 32'h0, SZ_BYTE, OP_READ);
    vecs[10] = mk(1, 0, 1, 0, OP_WRITE, 2'b00, 8'b0100_0000, 0, 32'h0, SZ_BYTE, OP_READ);
    vecs[11] = mk(1, 0, 0, 0, OP_WRITE, 2'b10, 8'h00, 1, 32'h8000_0000, SZ_HALF, OP_WRITE);
    vecs[12] = mk(1, 0, 0, 0, OP_WRITE, 2'b10, 8'b0000_0110, 0, 32'h0, SZ_BYTE, OP_READ);
    vecs[13] = mk(1, 1, 0, 0, OP_READ, 2'b01, 8'b1000_0000, 0, 32'h0, SZ_BYTE, OP_READ);
    vecs[14] = mk(1, 0, 0, 0, OP_READ, 2'b01, 8'h00, 1, 32'h0000_1000, SZ_WORD, OP_EXEC);
    vecs[15] = mk(1, 0, 0, 0, OP_READ, 2'b01, 8'b0001_0000, 0, 32'h0, SZ_BYTE, OP_READ);
    vecs[16] = mk(1, 0, 1, 0, OP_READ, 2'b01, 8'b0100_0000, 0, 32'h0, SZ_BYTE, OP_READ);
    vecs[17] = mk(1, 0, 1, 0, OP_READ, 2'b11, 8'h00, 1, 32'h8000_0000, SZ_HALF, OP_READ);
    vecs[18] = mk(1, 0, 1, 0, OP_READ, 2'b11, 8'b0000_0100, 0, 32'h0, SZ_BYTE, OP_READ);
    vecs[19] = mk(1, 0, 0, 0, OP_READ, 2'b00, 8'h00, 0, 32'h0, SZ_BYTE, OP_READ);

    nextCycle();
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clock);
      checkOutput($sformatf("vec%0d_ctl", i), 64'(outBits()), 64'(vecs[i].exp_ctl));
      if (vecs[i].chk) begin
        checkOutput($sformatf("vec%0d_pmp_fields", i),
                    64'({pmp_addr, pmp_size, pmp_oper}),
                    64'({vecs[i].exp_addr, vecs[i].exp_size, vecs[i].exp_oper}));
      end
      nextCycle();
    end

    // CSR write racing both checks: write first, one settle cycle, then a check grant.
    csr_wr_valid = 1'b1; if_req_valid = 1'b1; ls_req_valid = 1'b1;
    csr_addr = 32'h3A0; csr_wdata = 32'h0000_001F; pmp_rdata = 32'hCAFE_0001;
    @(negedge clock);
    checkOutput("csr_accept", 64'({if_req_ready, ls_req_ready, csr_wr_ready}), 64'(3'b001));
    checkOutput("csr_rw_passthru", 64'(pmp_rw_addr), 64'h3A0);
    checkOutput("csr_rdata", 64'(csr_rdata), 64'hCAFE_0001);
    nextCycle();
    csr_wr_valid = 1'b0; csr_addr = 32'h3B0; csr_wdata = 32'h0;
    @(negedge clock);
    checkOutput("csr_wr_pulse", 64'({pmp_wr_en, if_req_ready, ls_req_ready}), 64'(3'b100));
    checkOutput("csr_wr_addr", 64'(pmp_rw_addr), 64'h3A0);
    checkOutput("csr_wr_data", 64'(pmp_wdata), 64'h1F);
    nextCycle();
    @(negedge clock);
    checkOutput("csr_settle", 64'({pmp_wr_en, if_req_ready, ls_req_ready}), 64'(3'b000));
    checkOutput("csr_settle_passthru", 64'(pmp_rw_addr), 64'h3B0);
    nextCycle();
    @(negedge clock);
    checkOutput("csr_then_grant", 64'(int'(if_req_ready) + int'(ls_req_ready)), 64'd1);
    nextCycle();
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) nextCycle();

    // Both checkers held valid for four grants from a fresh reset.
    holdReset(3);
    if_req_valid = 1'b1; ls_req_valid = 1'b1; pmp_permission = 2'b01;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clock);
      if (if_req_ready || ls_req_ready) begin
        checkOutput($sformatf("arb_grant%0d", got),
                    64'({if_req_ready, ls_req_ready}), 64'(expGrant(got)));
        got++;
      end
      nextCycle();
    end
    checkOutput("arb_grant_count", 64'(got), 64'd4);
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) nextCycle();

    // Reset during CHECK drops the response; a re-issued request then completes.
    ls_req_valid = 1'b1; ls_oper = OP_READ;
    @(negedge clock);
    checkOutput("rstmid_grant", 64'(ls_req_ready), 64'd1);
    nextCycle();
    ls_req_valid = 1'b0; reset = 1'b0;
    @(negedge clock);
    nextCycle();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checkOutput($sformatf("rstmid_noresp%0d", c),
                  64'({if_resp_valid, ls_resp_valid}), 64'd0);
      nextCycle();
    end
    ls_req_valid = 1'b1; pmp_permission = 2'b00;
    granted = 1'b0;
    for (int c = 0; c < 6 && !granted; c++) begin
      @(negedge clock);
      if (ls_req_ready) granted = 1'b1;
      nextCycle();
    end
    checkOutput("reissue_grant", 64'(granted), 64'd1);
    ls_req_valid = 1'b0;
    @(negedge clock);
    checkOutput("reissue_check_cycle", 64'({ls_resp_valid, ls_resp_fault}), 64'd0);
    nextCycle();
    @(negedge clock);
    checkOutput("reissue_resp",
                64'({ls_resp_valid, ls_resp_fault, if_resp_valid}), 64'(3'b110));
    nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
